i2c_slave_responder: RTL and testbench
======================================

// Module: i2c_slave_responder
// PURPOSE
//  Synthesizable multi-address I2C slave responder; next-generation, parametrised replacement for the
//  behavioural i2c_if slave BFM used against the iicmb_m_wb controller. Oversamples SCL/SDA on clk_i,
//  ACKs a contiguous address window, captures write bytes into an RX FIFO, serves read bytes from a TX
//  FIFO, and reports a per-transfer summary. Sits on one open-drain bus of the controller's scl/sda vectors.
// PARAMETERS
//  ADDR_WIDTH   7      I2C address width
//  DATA_WIDTH   8      I2C byte width
//  BASE_ADDR    7'h22  first responding address
//  NUM_ADDRS    1      addresses BASE_ADDR..BASE_ADDR+NUM_ADDRS-1 answered (1..16)
//  FIFO_DEPTH   32     RX and TX FIFO depth, power of two
//  SYNC_STAGES  2      input synchroniser flops on scl_i/sda_i (>=2)
// PORTS
//  clk_i            in   1                    system clock, >=8x SCL rate
//  rst_n_i          in   1                    reset, asynchronous, active-low
//  scl_i / sda_i    in   1                    bus line levels
//  scl_o / sda_o    out  1                    open-drain drive: 0 = pull low, 1 = release
//  rx_data_o        out  DATA_WIDTH           RX FIFO head (write bytes from master)
//  rx_valid_o       out  1                    RX FIFO non-empty
//  rx_pop_i         in   1                    pop RX head this cycle (ignored when empty)
//  tx_data_i        in   DATA_WIDTH           byte for master reads
//  tx_push_i        in   1                    push tx_data_i (ignored when full)
//  tx_full_o        out  1                    TX FIFO full
//  xfer_done_o      out  1                    1-cycle pulse: addressed transfer ended (STOP or Sr)
//  xfer_op_o        out  1                    last transfer direction, 1 = read
//  xfer_idx_o       out  $clog2(NUM_ADDRS)+1  matched address minus BASE_ADDR
//  xfer_len_o       out  $clog2(FIFO_DEPTH)+1 data bytes completed (ACK/NACK phase done)
//  rx_ovf_o         out  1                    sticky: write byte dropped on full RX FIFO
// BEHAVIOUR
//  - Reset: scl_o=sda_o=1, FIFOs empty, rx_valid_o=0, tx_full_o=0, all xfer_* and rx_ovf_o = 0, FSM IDLE.
//  - Edges from synchronised lines; START = SDA fall with SCL high, STOP = SDA rise with SCL high.
//  - FSM: IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE.
//  - START from any state -> ADDR, bit count cleared; if an addressed transfer was active, xfer_done_o pulses.
//    STOP from any state -> IDLE, same pulse rule. Neither pulses while IDLE/IGNORE from no match.
//  - Bits sampled on SCL rise, MSB first. After 8th ADDR bit: in window -> ADDR_ACK, else IGNORE (no drive).
//  - ACK drive: sda_o=0 from SCL fall after bit 8 until the next SCL fall.
//  - WR_BYTE: 8th bit pushes byte to RX FIFO and ACKs; if RX full -> byte dropped, NACK, rx_ovf_o=1
//    until reset. Push and rx_pop_i in the same cycle both take effect.
//  - RD_BYTE: TX head popped at ADDR_ACK/RD_ACK end; bits driven on SCL fall; empty FIFO -> 8'hFF sent.
//    RD_ACK samples master on 9th SCL rise: ACK -> RD_BYTE, NACK -> IGNORE (lines released).
//  - xfer_len_o counts per transfer, saturates at FIFO_DEPTH; xfer_* latch when xfer_done_o pulses.
//  - Latency: line change to internal edge = SYNC_STAGES+1 clk_i; sda_o updates 1 clk after SCL fall detect.
//  - rst_n_i mid-transfer releases both lines immediately (async); bus resumes at next START.
// CONFIGURATION
//  I2C_SLV_STRETCH_EN defined: in RD_BYTE with TX FIFO empty, hold scl_o=0 from SCL fall until a byte is
//    pushed, then drive it; also stretches at WR_BYTE end while RX full instead of NACK (rx_ovf_o unused, 0).
//  Not defined: scl_o tied 1; empty TX -> 8'hFF, full RX -> NACK + rx_ovf_o as above.
// TESTING
//  1 Write 0x44 then bytes 0x00..0x1F, STOP -> 32 ACKs, RX pops 0..31, xfer_done_o=1 op=0 idx=0 len=32.
//  2 Preload TX 100..131; addr 0x45, read 32 (ACK x31, NACK last), STOP -> master gets 100..131, op=1 len=32.
//  3 NUM_ADDRS=4; addr 0x25 write 0xA5 -> ACK, idx=3; addr 0x26 -> NACK, no xfer_done_o pulse.
//  4 Write 33 bytes without popping -> 33rd NACKed, rx_ovf_o=1, RX holds first 32.
//  5 Write 2 bytes, Sr to read 1 byte (TX empty) -> two xfer_done_o pulses, read byte 0xFF
//    (STRETCH_EN: SCL held low until tx_push_i 0x5A, master reads 0x5A).
//  6 Assert rst_n_i mid read byte -> sda_o/scl_o =1 same cycle; next START+0x44 ACKed normally.

Source files
------------

// File: rtl/i2c_slave_responder.sv
// i2c_slave_responder: multi-address I2C slave with RX/TX FIFOs and a per-transfer summary.
// Define I2C_SLV_STRETCH_EN to stretch SCL on empty TX / full RX instead of sending 0xFF / NACK.
module i2c_slave_responder #(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 8,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 7'h22,
  parameter int NUM_ADDRS = 1,
  parameter int FIFO_DEPTH = 32,
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic scl_i,
  input  logic sda_i,
  output logic scl_o,
  output logic sda_o,
  output logic [DATA_WIDTH-1:0] rx_data_o,
  output logic rx_valid_o,
  input  logic rx_pop_i,
  input  logic [DATA_WIDTH-1:0] tx_data_i,
  input  logic tx_push_i,
  output logic tx_full_o,
  output logic xfer_done_o,
  output logic xfer_op_o,
  output logic [$clog2(NUM_ADDRS):0] xfer_idx_o,
  output logic [$clog2(FIFO_DEPTH):0] xfer_len_o,
  output logic rx_ovf_o
);
  localparam int IW = $clog2(NUM_ADDRS) + 1;
  localparam int LW = $clog2(FIFO_DEPTH) + 1;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, WR_BYTE, WR_ACK, RD_BYTE, RD_ACK, IGNORE} state_t;
  state_t state_q, state_d;
  logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
  logic scl_p_q, sda_p_q, scl_s, sda_s, rise, fall, start, stop;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] sh_q, sh_d, nsh, rx_wd, tx_head;
  logic [ADDR_WIDTH-1:0] off;
  logic hit, ld, rx_push, tx_pop, rx_full, tx_empty;
  logic ph_q, ph_d, sda_q, sda_d, hold_q, hold_d, nack_q, nack_d, rw_q, rw_d, act_q, act_d;
  logic done_q, done_d, op_q, op_d, ovf_q, ovf_d;
  logic [IW-1:0] idx_q, idx_d, xidx_q, xidx_d;
  logic [LW-1:0] len_q, len_d, len_inc, xlen_q, xlen_d;
  logic [LW-1:0] rx_wp_q, rx_rp_q, tx_wp_q, tx_rp_q, rx_cnt, tx_cnt;
  logic [DATA_WIDTH-1:0] rx_mem [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] tx_mem [FIFO_DEPTH];
  assign scl_s = scl_sync_q[SYNC_STAGES-1];
  assign sda_s = sda_sync_q[SYNC_STAGES-1];
  assign rise = scl_s & ~scl_p_q;
  assign fall = ~scl_s & scl_p_q;
  assign start = scl_s & scl_p_q & sda_p_q & ~sda_s;
  assign stop = scl_s & scl_p_q & ~sda_p_q & sda_s;
  assign nsh = {sh_q[DATA_WIDTH-2:0], sda_s};
  assign off = nsh[ADDR_WIDTH:1] - BASE_ADDR;
  assign hit = off < ADDR_WIDTH'(NUM_ADDRS);
  assign len_inc = (len_q == LW'(FIFO_DEPTH)) ? len_q : len_q + 1'b1;
  assign rx_cnt = rx_wp_q - rx_rp_q;
  assign tx_cnt = tx_wp_q - tx_rp_q;
  assign rx_full = rx_cnt[LW-1];
  assign rx_valid_o = |rx_cnt;
  assign tx_full_o = tx_cnt[LW-1];
  assign tx_empty = ~|tx_cnt;
  assign rx_data_o = rx_mem[rx_rp_q[LW-2:0]];
  assign tx_head = tx_mem[tx_rp_q[LW-2:0]];
  assign sda_o = sda_q;
`ifdef I2C_SLV_STRETCH_EN
  assign scl_o = ~hold_q;
`else
  assign scl_o = 1'b1;
`endif
  assign xfer_done_o = done_q;
  assign xfer_op_o = op_q;
  assign xfer_idx_o = xidx_q;
  assign xfer_len_o = xlen_q;
  assign rx_ovf_o = ovf_q;
  // Synchronise bus lines and keep the previous level for edge detection
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      scl_sync_q <= '1;
      sda_sync_q <= '1;
      scl_p_q <= 1'b1;
      sda_p_q <= 1'b1;
    end else begin
      scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl_i};
      sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda_i};
      scl_p_q <= scl_s;
      sda_p_q <= sda_s;
    end
  // FIFO storage needs no reset; pointers alone define occupancy
  always_ff @(posedge clk_i) begin
    if (rx_push) rx_mem[rx_wp_q[LW-2:0]] <= rx_wd;
    if (tx_push_i && !tx_full_o) tx_mem[tx_wp_q[LW-2:0]] <= tx_data_i;
  end
  // FIFO pointers; a push and a pop in the same cycle both take effect
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      rx_wp_q <= '0;
      rx_rp_q <= '0;
      tx_wp_q <= '0;
      tx_rp_q <= '0;
    end else begin
      rx_wp_q <= rx_wp_q + LW'(rx_push);
      rx_rp_q <= rx_rp_q + LW'(rx_pop_i && rx_valid_o);
      tx_wp_q <= tx_wp_q + LW'(tx_push_i && !tx_full_o);
      tx_rp_q <= tx_rp_q + LW'(tx_pop);
    end
  // Protocol state register; reset releases both lines at once
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      state_q <= IDLE; cnt_q <= '0; sh_q <= '0; ph_q <= 1'b0; sda_q <= 1'b1; hold_q <= 1'b0;
      nack_q <= 1'b0; rw_q <= 1'b0; idx_q <= '0; len_q <= '0; act_q <= 1'b0; done_q <= 1'b0;
      op_q <= 1'b0; xidx_q <= '0; xlen_q <= '0; ovf_q <= 1'b0;
    end else begin
      state_q <= state_d; cnt_q <= cnt_d; sh_q <= sh_d; ph_q <= ph_d; sda_q <= sda_d; hold_q <= hold_d;
      nack_q <= nack_d; rw_q <= rw_d; idx_q <= idx_d; len_q <= len_d; act_q <= act_d; done_q <= done_d;
      op_q <= op_d; xidx_q <= xidx_d; xlen_q <= xlen_d; ovf_q <= ovf_d;
    end
  // Next-state: START/STOP override everything, otherwise bit-level handling per state
  always_comb begin
    state_d = state_q; cnt_d = cnt_q; sh_d = sh_q; ph_d = ph_q; sda_d = sda_q; hold_d = hold_q;
    nack_d = nack_q; rw_d = rw_q; idx_d = idx_q; len_d = len_q; act_d = act_q; done_d = 1'b0;
    op_d = op_q; xidx_d = xidx_q; xlen_d = xlen_q; ovf_d = ovf_q;
    rx_push = 1'b0; rx_wd = sh_q; tx_pop = 1'b0; ld = 1'b0;
    if (start || stop) begin
      state_d = start ? ADDR : IDLE; cnt_d = '0; ph_d = 1'b0; sda_d = 1'b1; hold_d = 1'b0; act_d = 1'b0;
      if (act_q) begin
        done_d = 1'b1; op_d = rw_q; xidx_d = idx_q; xlen_d = len_q;
      end
    end else begin
      case (state_q)
        ADDR: if (rise) begin
          sh_d = nsh; cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(ADDR_WIDTH)) begin
            state_d = hit ? ADDR_ACK : IGNORE; act_d = hit; rw_d = nsh[0]; idx_d = IW'(off);
            len_d = '0; ph_d = 1'b0;
          end
        end
        ADDR_ACK: if (fall) begin
          if (!ph_q) begin
            sda_d = 1'b0; ph_d = 1'b1;
          end else begin
            ph_d = 1'b0; cnt_d = '0; sda_d = 1'b1; state_d = rw_q ? RD_BYTE : WR_BYTE; ld = rw_q;
          end
        end
        WR_BYTE: if (rise) begin
          sh_d = nsh; cnt_d = cnt_q + 1'b1;
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d = WR_ACK; ph_d = 1'b0;
`ifdef I2C_SLV_STRETCH_EN
            nack_d = 1'b0;
`else
            nack_d = rx_full; ovf_d = ovf_q | rx_full; rx_push = ~rx_full; rx_wd = nsh;
`endif
          end
        end
        WR_ACK: if ((fall || hold_q) && !ph_q) begin
`ifdef I2C_SLV_STRETCH_EN
          hold_d = rx_full; rx_push = ~rx_full; sda_d = rx_full | nack_q; ph_d = ~rx_full;
`else
          sda_d = nack_q; ph_d = 1'b1;
`endif
        end else if (fall) begin
          ph_d = 1'b0; cnt_d = '0; sda_d = 1'b1; len_d = len_inc; state_d = WR_BYTE;
        end
        RD_BYTE: if (hold_q) ld = 1'b1;
          else if (rise) cnt_d = cnt_q + 1'b1;
          else if (fall && cnt_q == CW'(DATA_WIDTH)) begin
            sda_d = 1'b1; state_d = RD_ACK;
          end else if (fall) begin
            sh_d = sh_q << 1; sda_d = sh_q[DATA_WIDTH-2];
          end
        RD_ACK: if (rise) begin
          len_d = len_inc; state_d = sda_s ? IGNORE : RD_ACK;
        end else if (fall) begin
          cnt_d = '0; state_d = RD_BYTE; ld = 1'b1;
        end
        default: ;
      endcase
      if (ld) begin
        tx_pop = ~tx_empty; sh_d = tx_head; sda_d = tx_empty | tx_head[DATA_WIDTH-1];
`ifdef I2C_SLV_STRETCH_EN
        hold_d = tx_empty;
`else
        if (tx_empty) sh_d = '1;
`endif
      end
    end
  end
endmodule

// File: tb/tb_i2c_slave_responder.sv
// tb_i2c_slave_responder: directed I2C master with scoreboards for write and read data.
module tb_i2c_slave_responder;
  localparam int Q = 8;
  logic clk = 1'b0, rst_n = 1'b1, m_scl = 1'b1, m_sda = 1'b1, rx_pop = 1'b0, tx_push = 1'b0;
  logic [7:0] tx_data = 8'h00;
  logic scl_o, sda_o, rx_valid, tx_full, done, op, ovf, bus_scl, bus_sda, a;
  logic [7:0] rx_data, r;
  logic [2:0] idx;
  logic [5:0] len;
  int n_cmp = 0, n_err = 0, n_done = 0;
  logic [7:0] rx_exp[$];
  logic [7:0] rd_exp[$];
  assign bus_scl = m_scl & scl_o;
  assign bus_sda = m_sda & sda_o;
  i2c_slave_responder #(.NUM_ADDRS(4)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .scl_i(bus_scl), .sda_i(bus_sda), .scl_o(scl_o), .sda_o(sda_o),
    .rx_data_o(rx_data), .rx_valid_o(rx_valid), .rx_pop_i(rx_pop), .tx_data_i(tx_data),
    .tx_push_i(tx_push), .tx_full_o(tx_full), .xfer_done_o(done), .xfer_op_o(op),
    .xfer_idx_o(idx), .xfer_len_o(len), .rx_ovf_o(ovf)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (done) n_done++;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic q();
    repeat (Q) @(negedge clk);
  endtask
  task automatic scl_hi();
    m_scl = 1'b1;
    for (int i = 0; i < 5000 && !bus_scl; i++) @(negedge clk);
    if (!bus_scl) chk("scl_release", bus_scl, 1);
  endtask
  task automatic start();
    m_sda = 1'b1; q(); scl_hi(); q(); m_sda = 1'b0; q(); m_scl = 1'b0; q();
  endtask
  task automatic stop();
    m_sda = 1'b0; q(); scl_hi(); q(); m_sda = 1'b1; q();
  endtask
  task automatic xbit(input logic b, output logic s);
    m_sda = b; q(); scl_hi(); q(); s = bus_sda; q(); m_scl = 1'b0; q();
  endtask
  task automatic xbyte(input logic [7:0] d, input logic last, output logic [7:0] rd, output logic ack);
    for (int i = 7; i >= 0; i--) xbit(d[i], rd[i]);
    xbit(last, ack);
  endtask
  task automatic wait_done(input int target);
    for (int i = 0; i < 60 && n_done < target; i++) @(negedge clk);
    chk("done_cnt", n_done, target);
  endtask
  task automatic summ(input string tag, input logic o, input logic [2:0] x, input logic [5:0] l);
    chk({tag, "_op"}, op, o);
    chk({tag, "_idx"}, idx, x);
    chk({tag, "_len"}, len, l);
  endtask
  task automatic drain(input string tag);
    logic [31:0] e;
    for (int i = 0; i < 40 && rx_valid; i++) begin
      e = 32'hFFFF_FFFF;
      if (rx_exp.size() != 0) e = 32'(rx_exp.pop_front());
      chk(tag, rx_data, e);
      rx_pop = 1'b1; @(negedge clk); rx_pop = 1'b0; @(negedge clk);
    end
    chk({tag, "_left"}, rx_exp.size(), 0);
  endtask
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_scl", scl_o, 1); chk("rst_sda", sda_o, 1); chk("rst_rxv", rx_valid, 0);
    chk("rst_txf", tx_full, 0); chk("rst_done", done, 0); chk("rst_ovf", ovf, 0);
    summ("rst", 1'b0, 3'd0, 6'd0);
    rst_n = 1'b1; q();
    start(); xbyte(8'h44, 1'b1, r, a); chk("t1_addr_ack", a, 0);
    for (int i = 0; i < 32; i++) begin
      rx_exp.push_back(8'(i)); xbyte(8'(i), 1'b1, r, a); chk("t1_ack", a, 0);
    end
    stop(); wait_done(1); summ("t1", 1'b0, 3'd0, 6'd32); drain("t1_rx");
    for (int i = 0; i < 32; i++) begin
      tx_data = 8'(100 + i); tx_push = 1'b1; rd_exp.push_back(8'(100 + i));
      @(negedge clk); tx_push = 1'b0; @(negedge clk);
    end
    chk("t2_txfull", tx_full, 1);
    start(); xbyte(8'h45, 1'b1, r, a); chk("t2_addr_ack", a, 0);
    for (int i = 0; i < 32; i++) begin
      xbyte(8'hFF, i == 31, r, a); chk("t2_rd", r, rd_exp.pop_front());
    end
    stop(); wait_done(2); summ("t2", 1'b1, 3'd0, 6'd32);
    start(); xbyte(8'h4A, 1'b1, r, a); chk("t3_addr_ack", a, 0);
    rx_exp.push_back(8'hA5); xbyte(8'hA5, 1'b1, r, a); chk("t3_ack", a, 0);
    stop(); wait_done(3); summ("t3", 1'b0, 3'd3, 6'd1); drain("t3_rx");
    start(); xbyte(8'h4C, 1'b1, r, a); chk("t3_addr_nack", a, 1);
    stop(); repeat (20) @(negedge clk); chk("t3_no_pulse", n_done, 3);
    start(); xbyte(8'h44, 1'b1, r, a); chk("t4_addr_ack", a, 0);
    for (int i = 0; i < 33; i++) begin
      if (i < 32) rx_exp.push_back(8'(64 + i));
      if (i == 32) chk("t4_ovf_pre", ovf, 0);
      xbyte(8'(64 + i), 1'b1, r, a); chk(i < 32 ? "t4_ack" : "t4_nack", a, i == 32);
    end
    stop(); wait_done(4); chk("t4_ovf", ovf, 1); summ("t4", 1'b0, 3'd0, 6'd32); drain("t4_rx");
    start(); xbyte(8'h44, 1'b1, r, a);
    rx_exp.push_back(8'h11); xbyte(8'h11, 1'b1, r, a);
    rx_exp.push_back(8'h22); xbyte(8'h22, 1'b1, r, a);
    start(); wait_done(5); summ("t5w", 1'b0, 3'd0, 6'd2);
    xbyte(8'h45, 1'b1, r, a); chk("t5_addr_ack", a, 0);
    rd_exp.push_back(8'hFF); xbyte(8'hFF, 1'b1, r, a); chk("t5_rd", r, rd_exp.pop_front());
    stop(); wait_done(6); summ("t5r", 1'b1, 3'd0, 6'd1); chk("t5_ovf_sticky", ovf, 1); drain("t5_rx");
    tx_data = 8'h00; tx_push = 1'b1; @(negedge clk); tx_push = 1'b0;
    start(); xbyte(8'h45, 1'b1, r, a); chk("t6_addr_ack", a, 0);
    xbit(1'b1, a); chk("t6_rd_bit", a, 0); chk("t6_sda_drv", sda_o, 0);
    rst_n = 1'b0; #1;
    chk("t6_rst_sda", sda_o, 1); chk("t6_rst_scl", scl_o, 1); chk("t6_rst_ovf", ovf, 0);
    @(negedge clk); rst_n = 1'b1; q();
    start(); xbyte(8'h44, 1'b1, r, a); chk("t6_post_ack", a, 0);
    stop(); wait_done(7); summ("t6", 1'b0, 3'd0, 6'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
